cdc_word_sender: RTL and testbench

Source-domain controller that sequences WIDTH-bit word transfers into the `syncron` crossing toward the DDS/LFSR clock domain. It accepts words from the Nios-side register logic through a valid/ready handshake and buffers one pending word. It holds `xfer_data` stable for a settle window before toggling a request line, then waits for the destination's toggle acknowledge, which it synchronizes internally. It also flags acknowledge timeouts.

---
 rtl/cdc_word_sender_if.sv | 31 +++
 rtl/cdc_word_sender.sv | 151 +++++++++++++++
 tb/tb_cdc_word_sender.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_word_sender_if.sv
`default_nettype none
// ============================================================================
// Module   : cdc_word_sender_if
// Brief    : Write handshake and crossing bus of the source-domain word sender.
// Revision : 1.0 - initial release
// ============================================================================
interface cdc_word_sender_if #(
   parameter int WIDTH = 12
);
   logic             wr_valid;
   logic [WIDTH-1:0] wr_data;
   logic             wr_ready;
   logic [WIDTH-1:0] xfer_data;
   logic             xfer_req;
   logic             xfer_ack;
   logic             busy;
   logic             done;
   logic             err;
   logic             err_clr;

   modport slave (
      input  wr_valid, wr_data, xfer_ack, err_clr,
      output wr_ready, xfer_data, xfer_req, busy, done, err
   );

   modport master (
      output wr_valid, wr_data, xfer_ack, err_clr,
      input  wr_ready, xfer_data, xfer_req, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/cdc_word_sender.sv
`default_nettype none
// ============================================================================
// Module   : cdc_word_sender
// Brief    : Sequences buffered words into a toggle req/ack crossing with
//            data settle window, ack synchronizer and sticky timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_word_sender #(
   parameter int WIDTH       = 12,
   parameter int SETTLE      = 2,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  wire logic          clk,
   input  wire logic          reset_n,
   cdc_word_sender_if.slave   bus
);
   localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int TCW = $clog2(TIMEOUT + 1);

   localparam logic [SCW-1:0] c_SETTLE_LAST = SCW'(SETTLE - 1);
   localparam logic [TCW-1:0] c_TO_LAST     = TCW'(TIMEOUT - 1);
   localparam logic [TCW-1:0] c_TO_MAX      = TCW'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETTLE   = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_ack_sync;
   logic                   r_pend_valid;
   logic [WIDTH-1:0]       r_pend_data;
   logic [WIDTH-1:0]       r_xfer_data;
   logic                   r_xfer_req;
   logic [SCW-1:0]         r_settle_cnt;
   logic [TCW-1:0]         r_to_cnt;
   logic                   r_done;
   logic                   r_err;
   logic                   r_wr_ready;
   logic                   r_busy;

   state_t                 w_state_nxt;
   logic                   w_pend_valid_nxt;
   logic [WIDTH-1:0]       w_pend_data_nxt;
   logic [WIDTH-1:0]       w_xfer_data_nxt;
   logic                   w_xfer_req_nxt;
   logic [SCW-1:0]         w_settle_cnt_nxt;
   logic [TCW-1:0]         w_to_cnt_nxt;
   logic                   w_done_nxt;
   logic                   w_err_set;
   logic                   w_err_nxt;
   logic                   w_busy_nxt;
   logic                   w_ack_s;
   logic                   w_accept;

   assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];
   assign w_accept = bus.wr_valid & r_wr_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_pend_valid_nxt = r_pend_valid;
      w_pend_data_nxt  = r_pend_data;
      w_xfer_data_nxt  = r_xfer_data;
      w_xfer_req_nxt   = r_xfer_req;
      w_settle_cnt_nxt = r_settle_cnt;
      w_to_cnt_nxt     = r_to_cnt;
      w_done_nxt       = 1'b0;
      w_err_set        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (r_pend_valid) begin
               w_xfer_data_nxt  = r_pend_data;
               w_pend_valid_nxt = 1'b0;
               w_settle_cnt_nxt = '0;
               w_state_nxt      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_settle_cnt == c_SETTLE_LAST) begin
               w_xfer_req_nxt = ~r_xfer_req;
               w_to_cnt_nxt   = '0;
               w_state_nxt    = ST_WAIT_ACK;
            end else begin
               w_settle_cnt_nxt = r_settle_cnt + SCW'(1);
            end
         end
         ST_WAIT_ACK: begin
            // A timed-out word keeps waiting; the request is never re-toggled.
            if (w_ack_s == r_xfer_req) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_to_cnt != c_TO_MAX) begin
               w_to_cnt_nxt = r_to_cnt + TCW'(1);
               w_err_set    = (r_to_cnt == c_TO_LAST);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      if (w_accept) begin
         w_pend_valid_nxt = 1'b1;
         w_pend_data_nxt  = bus.wr_data;
      end

      w_err_nxt  = w_err_set | (r_err & ~bus.err_clr);
      // busy reflects the state held during the current cycle, one edge late.
      w_busy_nxt = (r_state != ST_IDLE) | r_pend_valid;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_ack_sync   <= '0;
         r_pend_valid <= 1'b0;
         r_pend_data  <= '0;
         r_xfer_data  <= '0;
         r_xfer_req   <= 1'b0;
         r_settle_cnt <= '0;
         r_to_cnt     <= '0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_wr_ready   <= 1'b1;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_ack_sync   <= {r_ack_sync[SYNC_STAGES-2:0], bus.xfer_ack};
         r_pend_valid <= w_pend_valid_nxt;
         r_pend_data  <= w_pend_data_nxt;
         r_xfer_data  <= w_xfer_data_nxt;
         r_xfer_req   <= w_xfer_req_nxt;
         r_settle_cnt <= w_settle_cnt_nxt;
         r_to_cnt     <= w_to_cnt_nxt;
         r_done       <= w_done_nxt;
         r_err        <= w_err_nxt;
         r_wr_ready   <= ~w_pend_valid_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   assign bus.wr_ready  = r_wr_ready;
   assign bus.xfer_data = r_xfer_data;
   assign bus.xfer_req  = r_xfer_req;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cdc_word_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_word_sender
// Brief    : Directed plus randomized bench with a timeline-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_word_sender;
   localparam int P_SETTLE  = 2;
   localparam int P_SYNC    = 2;
   localparam int P_TIMEOUT = 8;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   cdc_word_sender_if #(.WIDTH(12)) bus ();

   cdc_word_sender #(
      .WIDTH       (12),
      .SETTLE      (P_SETTLE),
      .SYNC_STAGES (P_SYNC),
      .TIMEOUT     (P_TIMEOUT)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference: a word is defined by the edge it was loaded at; everything
   // else (toggle edge, timeout edge) follows from that timestamp.
   logic        m_pend_valid = 1'b0;
   logic [11:0] m_pend_data  = '0;
   logic        m_active     = 1'b0;
   int          m_load       = 0;
   logic [11:0] m_data       = '0;
   logic        m_req        = 1'b0;
   logic        m_done       = 1'b0;
   logic        m_err        = 1'b0;
   logic        m_busy       = 1'b0;
   logic        ahist [P_SYNC];

   bit  ack_auto  = 1'b1;
   int  ack_delay = 3;
   int  spur_cnt  = 0;

   int          done_q[$];
   logic [11:0] data_log[$];
   int          req_toggles = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic model_step();
      logic ack_s;
      logic o_active;
      logic o_pend;
      logic set_err;
      cyc++;
      ack_s = ahist[P_SYNC-1];
      for (int i = P_SYNC - 1; i > 0; i--) ahist[i] = ahist[i-1];
      ahist[0] = bus.xfer_ack;
      if (!reset_n) begin
         for (int i = 0; i < P_SYNC; i++) ahist[i] = 1'b0;
         m_pend_valid = 1'b0; m_pend_data = '0; m_active = 1'b0;
         m_data = '0; m_req = 1'b0; m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
      end else begin
         o_active = m_active;
         o_pend   = m_pend_valid;
         set_err  = 1'b0;
         m_done   = 1'b0;
         m_busy   = o_active | o_pend;
         if (!o_active && o_pend) begin
            m_active = 1'b1; m_load = cyc; m_data = m_pend_data; m_pend_valid = 1'b0;
         end else if (o_active) begin
            if (cyc == m_load + P_SETTLE) m_req = ~m_req;
            else if (cyc > m_load + P_SETTLE) begin
               if (ack_s == m_req) begin
                  m_done = 1'b1; m_active = 1'b0;
               end else if (cyc == m_load + P_SETTLE + P_TIMEOUT) set_err = 1'b1;
            end
         end
         if (bus.wr_valid && !o_pend) begin
            m_pend_valid = 1'b1; m_pend_data = bus.wr_data;
         end
         if (set_err) m_err = 1'b1;
         else if (bus.err_clr) m_err = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < P_SYNC; i++) ahist[i] = 1'b0;
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Per-cycle compare plus event logging.
   initial begin
      logic        prev_req;
      logic [11:0] prev_data;
      prev_req  = 1'b0;
      prev_data = '0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         cmp("wr_ready",  bus.wr_ready,  !m_pend_valid);
         cmp("xfer_data", bus.xfer_data, m_data);
         cmp("xfer_req",  bus.xfer_req,  m_req);
         cmp("busy",      bus.busy,      m_busy);
         cmp("done",      bus.done,      m_done);
         cmp("err",       bus.err,       m_err);
         if (bus.done === 1'b1) done_q.push_back(cyc);
         if (bus.xfer_req !== prev_req) req_toggles++;
         if (bus.xfer_data !== prev_data) data_log.push_back(bus.xfer_data);
         prev_req  = bus.xfer_req;
         prev_data = bus.xfer_data;
      end
   end

   // Destination side: echoes xfer_req onto xfer_ack after ack_delay cycles.
   initial begin
      int lag;
      int spur_seen;
      lag = 0;
      spur_seen = 0;
      bus.xfer_ack = 1'b0;
      forever begin
         @(posedge clk);
         #3;
         if (!reset_n) begin
            bus.xfer_ack = 1'b0; lag = 0;
         end else if (spur_seen != spur_cnt) begin
            bus.xfer_ack = ~bus.xfer_ack; spur_seen = spur_cnt;
         end else if (ack_auto && (bus.xfer_req !== bus.xfer_ack)) begin
            lag++;
            if (lag >= ack_delay) begin
               bus.xfer_ack = bus.xfer_req; lag = 0;
            end
         end else begin
            lag = 0;
         end
      end
   end

   task automatic send(input logic [11:0] w, output int e);
      int n;
      n = 0;
      bus.wr_valid = 1'b1;
      bus.wr_data  = w;
      while (!bus.wr_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         n_cmp++; n_bad++;
         $display("FAIL send_stall: wr_ready=0 after %0d cycles, expected 1", n);
      end
      tick();
      e = cyc;
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      tick();
      while ((bus.busy || !bus.wr_ready) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_idle: busy=%0b after %0d cycles, expected 0", bus.busy, budget);
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, e1, e2, e3, n0, t0, ds;
      reset_n      = 1'b0;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 12'hFFF;
      bus.err_clr  = 1'b0;
      repeat (3) tick();
      cmp("rst_wr_ready",  bus.wr_ready,  1);
      cmp("rst_busy",      bus.busy,      0);
      cmp("rst_xfer_req",  bus.xfer_req,  0);
      cmp("rst_xfer_data", bus.xfer_data, 0);
      cmp("rst_done",      bus.done,      0);
      cmp("rst_err",       bus.err,       0);
      bus.wr_valid = 1'b0;
      reset_n      = 1'b1;
      tick();
      cmp("rel_wr_ready", bus.wr_ready, 1);
      cmp("rel_busy",     bus.busy,     0);

      // Single word, ack echoed 3 cycles after the request toggle.
      n0 = done_q.size();
      send(12'hA5C, e0);
      cmp("sw_data_e0", bus.xfer_data, 0);
      tick(); cmp("sw_data_load", bus.xfer_data, 12'hA5C);
      tick(); cmp("sw_req_hold",  bus.xfer_req,  0);
      tick(); cmp("sw_req_tog",   bus.xfer_req,  1);
      wait_idle(100);
      cmp("sw_done_cnt", done_q.size() - n0, 1);
      if (done_q.size() > n0) cmp("sw_done_edge", done_q[n0] - e0, 8);

      // Three back-to-back words; the third stalls until the first is done.
      n0 = done_q.size(); t0 = req_toggles; ds = data_log.size();
      send(12'h001, e1);
      send(12'h002, e2);
      bus.wr_data = 12'h003;
      cmp("b2b_stall", bus.wr_ready, 0);
      send(12'h003, e3);
      if (done_q.size() > n0) cmp("b2b_third_accept", e3 - done_q[n0], 2);
      else cmp("b2b_first_done_seen", done_q.size() - n0, 1);
      wait_idle(200);
      cmp("b2b_done_cnt", done_q.size() - n0, 3);
      cmp("b2b_toggles", req_toggles - t0, 3);
      cmp("b2b_data_n", data_log.size() - ds, 3);
      if (data_log.size() >= ds + 3) begin
         cmp("b2b_data0", data_log[ds],   12'h001);
         cmp("b2b_data1", data_log[ds+1], 12'h002);
         cmp("b2b_data2", data_log[ds+2], 12'h003);
      end

      // Timeout: no ack, err after TIMEOUT cycles in WAIT_ACK, then late ack.
      ack_auto = 1'b0;
      n0 = done_q.size();
      send(12'h7E7, e0);
      repeat (10) tick();
      cmp("to_err_before", bus.err, 0);
      tick();
      cmp("to_err_set", bus.err, 1);
      cmp("to_busy", bus.busy, 1);
      repeat (5) tick();
      cmp("to_busy_hold", bus.busy, 1);
      cmp("to_no_done", done_q.size() - n0, 0);
      ack_auto = 1'b1;
      wait_idle(100);
      cmp("to_late_done", done_q.size() - n0, 1);
      cmp("to_err_sticky", bus.err, 1);
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      cmp("to_err_clr", bus.err, 0);

      // Spurious ack toggle in IDLE, then a word whose request matches it.
      ack_auto = 1'b0;
      tick();
      n0 = done_q.size();
      spur_cnt++;
      repeat (6) tick();
      cmp("spur_no_done", done_q.size() - n0, 0);
      send(12'h3C3, e0);
      wait_idle(100);
      cmp("spur_done_cnt", done_q.size() - n0, 1);
      if (done_q.size() > n0) cmp("spur_done_edge", done_q[n0] - e0, 4);
      ack_auto = 1'b1;
      repeat (4) tick();

      // Reset in WAIT_ACK with a second word pending.
      ack_auto = 1'b0;
      send(12'h011, e0);
      send(12'h022, e1);
      repeat (2) tick();
      cmp("mid_wait_busy", bus.busy, 1);
      reset_n = 1'b0;
      tick();
      cmp("mid_rst_req",      bus.xfer_req, 0);
      cmp("mid_rst_wr_ready", bus.wr_ready, 1);
      cmp("mid_rst_done",     bus.done,     0);
      cmp("mid_rst_err",      bus.err,      0);
      cmp("mid_rst_busy",     bus.busy,     0);
      tick();
      reset_n  = 1'b1;
      ack_auto = 1'b1;
      tick();

      // Randomized traffic, ack delays straddling TIMEOUT, occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bus.wr_valid = ($urandom_range(0, 2) != 0);
         bus.wr_data  = 12'($urandom);
         bus.err_clr  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 19) == 0) ack_delay = $urandom_range(0, 14);
         if ($urandom_range(0, 199) == 0) spur_cnt++;
         reset_n = ($urandom_range(0, 499) != 0);
         tick();
      end
      bus.wr_valid = 1'b0;
      bus.err_clr  = 1'b0;
      reset_n      = 1'b1;
      ack_delay    = 2;
      wait_idle(300);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
